// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream handshake into the boot loader
interface imem_boot_loader_if;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_ready_o;

    modport master (
        output in_data_i,
        output in_valid_i,
        input  in_ready_o
    );

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        output in_ready_o
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - decodes load frames into imem/dmem writes and gates CPU start
module imem_boot_loader #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    imem_boot_loader_if.slave  in_s,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        imem_data_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [7:0]         dmem_data_o,
    output logic               start_o,
    output logic               err_o,
    output logic [8:0]         words_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_WR,
        S_RUN
    } state_e;

    state_e             state_q, state_d;
    logic               is_imem_q, is_imem_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        word_q, word_d;
    logic [7:0]         dbyte_q, dbyte_d;
    logic               err_q, err_d;
    logic [8:0]         words_q, words_d;
    logic               ready;
    logic               accept;

    assign ready  = (state_q != S_WR);
    assign accept = in_s.in_valid_i && ready;

    always_comb begin
        state_d     = state_q;
        is_imem_d   = is_imem_q;
        imem_addr_d = imem_addr_q;
        dmem_addr_d = dmem_addr_q;
        cnt_d       = cnt_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        dbyte_d     = dbyte_q;
        err_d       = err_q;
        words_d     = words_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (in_s.in_data_i)
                        8'h01: begin
                            is_imem_d = 1'b1;
                            state_d   = S_ADDR;
                        end
                        8'h02: begin
                            is_imem_d = 1'b0;
                            state_d   = S_ADDR;
                        end
                        8'h03:   state_d = S_RUN;
                        default: err_d   = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if (is_imem_q) imem_addr_d = IMEM_AW'(in_s.in_data_i);
                    else           dmem_addr_d = DMEM_AW'(in_s.in_data_i);
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (accept) begin
                    cnt_d      = in_s.in_data_i;
                    byte_idx_d = 2'd0;
                    state_d    = (in_s.in_data_i == 8'd0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (is_imem_q) begin
                        // Little-endian assembly: lane 0 is the first byte received
                        word_d[8*byte_idx_q +: 8] = in_s.in_data_i;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) state_d = S_WR;
                    end else begin
                        dbyte_d = in_s.in_data_i;
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                if (is_imem_q) begin
                    imem_addr_d = imem_addr_q + 1'b1;
                    if (words_q != 9'h1FF) words_d = words_q + 9'd1;
                end else begin
                    dmem_addr_d = dmem_addr_q + 1'b1;
                end
                cnt_d      = cnt_q - 8'd1;
                byte_idx_d = 2'd0;
                state_d    = (cnt_q == 8'd1) ? S_IDLE : S_DATA;
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            is_imem_q   <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            cnt_q       <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            dbyte_q     <= '0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            is_imem_q   <= is_imem_d;
            imem_addr_q <= imem_addr_d;
            dmem_addr_q <= dmem_addr_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            dbyte_q     <= dbyte_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    // Ready is held low while reset is asserted so no byte appears accepted
    assign in_s.in_ready_o = ready && rst_i;
    assign imem_we_o       = (state_q == S_WR) && is_imem_q;
    assign dmem_we_o       = (state_q == S_WR) && !is_imem_q;
    assign imem_addr_o     = imem_addr_q;
    assign imem_data_o     = word_q;
    assign dmem_addr_o     = dmem_addr_q;
    assign dmem_data_o     = dbyte_q;
    assign start_o         = (state_q == S_RUN);
    assign err_o           = err_q;
    assign words_o         = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        dmem_we;
    logic [4:0]  dmem_addr;
    logic [7:0]  dmem_data;
    logic        start;
    logic        err;
    logic [8:0]  words;

    int n_cmp = 0;
    int n_bad = 0;

    logic [39:0] ilog[$];
    logic [12:0] dlog[$];
    int          ready_low = 0;
    int          both_we = 0;

    imem_boot_loader_if bus();

    imem_boot_loader #(.IMEM_AW(8), .DMEM_AW(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .in_s       (bus),
        .imem_we_o  (imem_we),
        .imem_addr_o(imem_addr),
        .imem_data_o(imem_data),
        .dmem_we_o  (dmem_we),
        .dmem_addr_o(dmem_addr),
        .dmem_data_o(dmem_data),
        .start_o    (start),
        .err_o      (err),
        .words_o    (words)
    );

    always #5 clk = ~clk;

    // Observe outputs 2ns after each rising edge; tasks act on falling edges
    always begin
        @(posedge clk);
        #2;
        if (imem_we) ilog.push_back({imem_addr, imem_data});
        if (dmem_we) dlog.push_back({dmem_addr, dmem_data});
        if (!bus.in_ready_o) ready_low++;
        if (imem_we && dmem_we) both_we++;
    end

    function automatic logic [39:0] ient(input int i);
        return (i < ilog.size()) ? ilog[i] : 40'hx;
    endfunction

    function automatic logic [12:0] dent(input int i);
        return (i < dlog.size()) ? dlog[i] : 13'hx;
    endfunction

    task automatic clear_logs();
        ilog.delete();
        dlog.delete();
        ready_low = 0;
    endtask

    task automatic idle(input int n);
        bus.in_valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        bit r;
        ok = 1'b0;
        bus.in_data_i  = b;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            r = bus.in_ready_o;
            @(negedge clk);
            if (r) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte_timeout byte=%h never accepted within 20 cycles", b);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic do_reset();
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_we, dmem_we, start, err, words, bus.in_ready_o} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got we=%b%b start=%b err=%b words=%0d rdy=%b exp all 0",
                     imem_we, dmem_we, start, err, words, bus.in_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b exp 1", bus.in_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_data_i  = 8'h00;
        bus.in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
    endtask

    task automatic test_imem_basic();
        clear_logs();
        send_seq('{8'h01, 8'h00, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00}, 0);
        n_cmp++;
        if (imem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL imem_latency we=%b exp 1 in cycle after last byte", imem_we);
        end
        send_seq('{8'h93, 8'h08, 8'h40, 8'h00}, 0);
        idle(3);
        n_cmp++;
        if (ilog.size() !== 2) begin n_bad++; $display("FAIL imem_basic_count got %0d exp 2", ilog.size()); end
        n_cmp++;
        if (ient(0) !== {8'h00, 32'h0000_0013}) begin n_bad++; $display("FAIL imem_basic_w0 got %h exp 0000000013", ient(0)); end
        n_cmp++;
        if (ient(1) !== {8'h01, 32'h0040_0893}) begin n_bad++; $display("FAIL imem_basic_w1 got %h exp 0100400893", ient(1)); end
        n_cmp++;
        if (words !== 9'd2) begin n_bad++; $display("FAIL imem_basic_words got %0d exp 2", words); end
        n_cmp++;
        if (ready_low !== 2) begin n_bad++; $display("FAIL imem_basic_ready_low got %0d exp 2", ready_low); end
        n_cmp++;
        if (dlog.size() !== 0) begin n_bad++; $display("FAIL imem_basic_no_dmem got %0d exp 0", dlog.size()); end
    endtask

    task automatic test_dmem_wrap();
        clear_logs();
        send_seq('{8'h02, 8'h1F, 8'h02, 8'h05, 8'h07}, 0);
        idle(3);
        n_cmp++;
        if (dlog.size() !== 2) begin n_bad++; $display("FAIL dmem_count got %0d exp 2", dlog.size()); end
        n_cmp++;
        if (dent(0) !== {5'd31, 8'h05}) begin n_bad++; $display("FAIL dmem_w0 got %h exp %h", dent(0), {5'd31, 8'h05}); end
        n_cmp++;
        if (dent(1) !== {5'd0, 8'h07}) begin n_bad++; $display("FAIL dmem_w1 got %h exp %h", dent(1), {5'd0, 8'h07}); end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL dmem_err got %b exp 0", err); end
        n_cmp++;
        if (ilog.size() !== 0) begin n_bad++; $display("FAIL dmem_no_imem got %0d exp 0", ilog.size()); end
    endtask

    task automatic test_imem_wrap();
        clear_logs();
        send_seq('{8'h01, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08}, 0);
        idle(3);
        n_cmp++;
        if (ilog.size() !== 2) begin n_bad++; $display("FAIL imem_wrap_count got %0d exp 2", ilog.size()); end
        n_cmp++;
        if (ient(0) !== {8'hFF, 32'h0403_0201}) begin n_bad++; $display("FAIL imem_wrap_w0 got %h exp ff04030201", ient(0)); end
        n_cmp++;
        if (ient(1) !== {8'h00, 32'h0807_0605}) begin n_bad++; $display("FAIL imem_wrap_w1 got %h exp 0008070605", ient(1)); end
        n_cmp++;
        if (words !== 9'd4) begin n_bad++; $display("FAIL imem_wrap_words got %0d exp 4", words); end
    endtask

    task automatic test_throttle_reset();
        clear_logs();
        send_seq('{8'h01, 8'h05, 8'h01, 8'h11, 8'h22}, 1);
        idle(4);
        n_cmp++;
        if (ilog.size() !== 0) begin n_bad++; $display("FAIL throttle_no_write got %0d exp 0", ilog.size()); end
        do_reset();
        n_cmp++;
        if (words !== 9'd0) begin n_bad++; $display("FAIL throttle_words_cleared got %0d exp 0", words); end
        clear_logs();
        send_seq('{8'h01, 8'h05, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11}, 0);
        idle(3);
        n_cmp++;
        if (ilog.size() !== 1) begin n_bad++; $display("FAIL after_reset_count got %0d exp 1", ilog.size()); end
        n_cmp++;
        if (ient(0) !== {8'h05, 32'h1122_3344}) begin n_bad++; $display("FAIL after_reset_word got %h exp 0511223344", ient(0)); end
        n_cmp++;
        if (words !== 9'd1) begin n_bad++; $display("FAIL after_reset_words got %0d exp 1", words); end
    endtask

    task automatic test_bad_cmd_start();
        clear_logs();
        send_byte(8'h7E);
        idle(1);
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL bad_cmd_err got %b exp 1", err); end
        send_seq('{8'h01, 8'h10, 8'h00}, 0);
        idle(3);
        n_cmp++;
        if (ilog.size() + dlog.size() !== 0) begin
            n_bad++;
            $display("FAIL zero_cnt_no_write got %0d exp 0", ilog.size() + dlog.size());
        end
        n_cmp++;
        if (start !== 1'b0) begin n_bad++; $display("FAIL start_before got %b exp 0", start); end
        send_byte(8'h03);
        n_cmp++;
        if (start !== 1'b1) begin n_bad++; $display("FAIL start_after got %b exp 1", start); end
    endtask

    task automatic test_run_discard();
        clear_logs();
        send_seq('{8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0);
        idle(3);
        n_cmp++;
        if (ilog.size() + dlog.size() !== 0) begin
            n_bad++;
            $display("FAIL run_no_write got %0d exp 0", ilog.size() + dlog.size());
        end
        n_cmp++;
        if (start !== 1'b1) begin n_bad++; $display("FAIL run_start got %b exp 1", start); end
        n_cmp++;
        if (ready_low !== 0) begin n_bad++; $display("FAIL run_ready_low got %0d exp 0", ready_low); end
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL run_err_held got %b exp 1", err); end
        do_reset();
        n_cmp++;
        if ({start, err} !== 2'b00) begin n_bad++; $display("FAIL run_reset_clear got %b%b exp 00", start, err); end
    endtask

    initial begin
        test_reset();
        test_imem_basic();
        test_dmem_wrap();
        test_imem_wrap();
        test_throttle_reset();
        test_bad_cmd_start();
        test_run_discard();
        n_cmp++;
        if (both_we !== 0) begin n_bad++; $display("FAIL both_we got %0d exp 0", both_we); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware counterpart to the bench-side memory preload and start sequencing.
- Accepts a byte stream over a valid/ready handshake, decodes load frames, and writes 32-bit words into instruction memory and bytes into data memory.
- Holds the CPU's start low until a start command arrives.
- Sits between the host/UART byte source and the CPU's memory write ports and start_i.

Parameters:
- IMEM_AW, 8, instruction-memory word-address width (256 words).
- DMEM_AW, 5, data-memory byte-address width (32 bytes).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- in_data_i  input  8  stream byte.
- in_valid_i  input  1  byte valid.
- in_ready_o  output  1  loader can accept a byte; transfer occurs when in_valid_i and in_ready_o are both 1 at a rising edge.
- imem_we_o  output  1  instruction-memory write strobe, 1-cycle pulse.
- imem_addr_o  output  IMEM_AW  instruction word index.
- imem_data_o  output  32  instruction word.
- dmem_we_o  output  1  data-memory write strobe, 1-cycle pulse.
- dmem_addr_o  output  DMEM_AW  data byte address.
- dmem_data_o  output  8  data byte.
- start_o  output  1  CPU start; drives CPU start_i.
- err_o  output  1  sticky protocol error.
- words_o  output  9  count of instruction words written, saturating at 511.

Behaviour:
- Reset (async, rst_i=0):
  - State = IDLE.
  - All outputs 0, except in_ready_o, which is 1 once reset is released.
  - Byte index, address and count registers cleared.
- Frame format:
  - CMD byte: 0x01 = imem load, 0x02 = dmem load, 0x03 = start.
  - For 0x01/0x02, CMD is followed by ADDR (start address), then CNT (words for 0x01, bytes for 0x02), then payload.
  - imem words are little-endian: first byte is bits [7:0].
- States: IDLE, ADDR, CNT, DATA, WR, RUN.
- IDLE, on an accepted byte:
  - 0x01 or 0x02: latch the command, go to ADDR.
  - 0x03: go to RUN.
  - Any other value: set err_o, stay in IDLE, byte dropped.
- ADDR: accepted byte is truncated to IMEM_AW or DMEM_AW bits and latched as the address; go to CNT.
- CNT:
  - Latch the count.
  - CNT=0: return to IDLE with no writes.
  - Otherwise: go to DATA, byte index = 0.
- DATA, imem command:
  - Shift each accepted byte into the assembly register at lane byte_idx.
  - On the 4th byte, go to WR.
- DATA, dmem command: every accepted byte goes to WR.
- WR (exactly 1 cycle):
  - in_ready_o = 0.
  - Assert the relevant we_o with registered addr/data.
  - Increment the address modulo 2^AW (wraps 255→0 for imem, 31→0 for dmem).
  - Decrement the count.
  - If the count reaches 0, go to IDLE; else go to DATA.
- words_o increments on each imem_we_o pulse and saturates at 511.
- Write latency: the we_o pulse occurs in the cycle after the final byte of a word (imem) or after the byte (dmem) is accepted.
- in_ready_o: 1 in every state except WR.
- RUN:
  - start_o = 1 from the first cycle in RUN until reset.
  - in_ready_o = 1; all bytes are discarded.
  - No writes; err_o unchanged.
- in_valid_i=0 in any state: no state change; a partial word is held indefinitely.
- Reset mid-frame: the partial word is discarded with no write; start_o and err_o are cleared.
- err_o clears only on reset.
- we_o are never asserted outside WR, and imem_we_o and dmem_we_o are never asserted together.

Test Plan:
- Imem load, basic:
  - Stimulus: 01 00 02 | 13 00 00 00 | 93 08 40 00 with valid held high.
  - Required: imem_we_o pulses at addr 0 data 0x00000013, then at addr 1 data 0x00400893; words_o=2; in_ready_o low exactly 2 cycles total; state IDLE after.
- Dmem load with wrap:
  - Stimulus: 02 1F 02 05 07.
  - Required: dmem writes (addr 31, 0x05) then (addr 0, 0x07); err_o=0.
- Bad command, zero count, start:
  - Stimulus: 7E, then 01 10 00, then 03.
  - Required: err_o=1 after 7E; no write for the CNT=0 frame; start_o=1 the cycle after 03 is accepted.
- Bytes after start:
  - Stimulus: in RUN, send 01 00 01 AA BB CC DD.
  - Required: no we_o pulses; start_o stays 1; in_ready_o stays 1.
- Throttled valid and reset mid-frame:
  - Stimulus: send 01 05 01 11 22 with in_valid_i toggling every other cycle, then drop rst_i for 1 cycle.
  - Required: no imem_we_o; all outputs return to 0; a subsequent 01 05 01 44 33 22 11 writes 0x11223344 to addr 5.
- Imem address wrap:
  - Stimulus: 01 FF 02 followed by 8 bytes.
  - Required: writes at addr 255 then addr 0.
